instruction_memory: RTL and testbench

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

---
 rtl/instruction_memory.sv | 92 +++++++++
 tb/tb_instruction_memory.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// ---------------------------------------------------------------------------
// instruction_memory
//   Word-organised instruction store with a zero-latency fetch port and a
//   clocked program-load port. Fetch and load addresses are byte addresses;
//   the low two bits never take part in indexing.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   INIT_FILE    optional hex image name (empty = none)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (clears fault only)
//   address      fetch byte address
//   instruction  mem[address[31:2]], or zero when out of range
//   load_en      program-load write strobe
//   load_addr    program-load byte address
//   load_data    program-load write data
//   misaligned   address[1:0] != 0 (combinational)
//   out_of_range address[31:2] >= DEPTH (combinational)
//   fault        sticky error flag, registered, cleared only by reset
// ---------------------------------------------------------------------------
module instruction_memory #(
  parameter int unsigned DEPTH     = 256,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic          w_rd_oob;
  logic          w_ld_oob;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_ld_idx;
  logic [1:0]    w_unused_load_lsb;
  logic          r_fault;

  // Every word starts at zero so unwritten locations never read as X.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  // Range tests use the full word address so an oversized address is
  // flagged instead of wrapping onto a low word.
  assign w_rd_oob          = (address[31:2]   >= 30'(DEPTH));
  assign w_ld_oob          = (load_addr[31:2] >= 30'(DEPTH));
  assign w_rd_idx          = address[AW+1:2];
  assign w_ld_idx          = load_addr[AW+1:2];
  assign w_unused_load_lsb = load_addr[1:0];

  always_comb begin
    instruction = '0;
    if (!w_rd_oob) begin
      instruction = mem[w_rd_idx];
    end
  end

  assign misaligned   = (address[1:0] != 2'b00);
  assign out_of_range = w_rd_oob;
  assign fault        = r_fault;

  // reset is sampled at the edge here: it blocks the write but never
  // touches stored contents.
  always_ff @(posedge clk) begin
    if (load_en && !reset && !w_ld_oob) begin
      mem[w_ld_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (misaligned || w_rd_oob || (load_en && w_ld_oob)) begin
      r_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// ---------------------------------------------------------------------------
// tb_instruction_memory
//   Self-checking bench for instruction_memory (DEPTH overridden to 16).
//   Expected fetch words come from a bench-side model of the array and flow
//   through a scoreboard queue: pushed when the address is driven, popped
//   when the fetch output is sampled.
// ---------------------------------------------------------------------------
module tb_instruction_memory;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] instruction;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;

    instruction_memory #(
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .instruction (instruction),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .out_of_range(out_of_range),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] model [DEPTH];

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected fetch word for a byte address, from the bench model.
    function automatic logic [31:0] model_fetch(input logic [31:0] a);
        if (a[31:2] >= 30'(DEPTH)) return '0;
        return model[a[31:2]];
    endfunction

    // Drive a fetch address and queue the word it must return.
    task automatic drive_fetch(input string tag, input logic [31:0] a);
        address = a;
        sb.push_back('{tag, model_fetch(a)});
    endtask

    // Sample the fetch output and retire the oldest scoreboard entry.
    task automatic sample_fetch();
        sb_item_t it;
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            it = sb.pop_front();
            chk(it.tag, instruction, it.exp);
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        if (!reset && (a[31:2] < 30'(DEPTH))) model[a[31:2]] = d;
        #1;
        load_en = 1'b0;
    endtask

    // Pulse reset between clock edges and confirm fault clears at once.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk(tag, {31'd0, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

        #1 reset = 1'b1;
        drive_fetch("reset_instr", 32'h0);
        sample_fetch();
        chk("reset_fault", {31'd0, fault}, 32'd0);
        chk("reset_misal", {31'd0, misaligned}, 32'd0);
        chk("reset_oor",   {31'd0, out_of_range}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Program image through the load port.
        do_load(32'h0000_0000, 32'h1234_5678);
        do_load(32'h0000_0004, 32'h9ABC_DEF0);
        do_load(32'h0000_000C, 32'hCAFE_BABE);

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive_fetch($sformatf("fetch_%0h", i * 4), 32'(i * 4));
            sample_fetch();
            chk("aligned_misal", {31'd0, misaligned}, 32'd0);
            chk("aligned_oor",   {31'd0, out_of_range}, 32'd0);
        end
        chk("aligned_fault", {31'd0, fault}, 32'd0);

        // Misaligned fetch: low bits ignored, flag immediate, fault after edge.
        drive_fetch("misal_instr", 32'h0000_0005);
        sample_fetch();
        chk("misal_flag", {31'd0, misaligned}, 32'd1);
        chk("misal_fault_pre", {31'd0, fault}, 32'd0);
        @(posedge clk);
        #1;
        chk("misal_fault_post", {31'd0, fault}, 32'd1);
        @(negedge clk);
        drive_fetch("misal_e_instr", 32'h0000_000E);
        sample_fetch();
        address = 32'h0;

        reset_pulse("misal_fault_clr");
        drive_fetch("instr_after_rst", 32'h0);
        sample_fetch();

        // Highest in-range word, then the first out-of-range address.
        do_load(32'h0000_003C, 32'h1111_2222);
        @(negedge clk);
        drive_fetch("top_word", 32'h0000_003C);
        sample_fetch();
        chk("top_oor", {31'd0, out_of_range}, 32'd0);
        drive_fetch("oor_instr", 32'(4 * DEPTH));
        sample_fetch();
        chk("oor_flag", {31'd0, out_of_range}, 32'd1);
        @(posedge clk);
        #1;
        chk("oor_fault", {31'd0, fault}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("oor_fault_async_clr", {31'd0, fault}, 32'd0);
        chk("oor_flag_in_reset", {31'd0, out_of_range}, 32'd1);
        @(posedge clk);
        #1;
        chk("oor_fault_held_in_reset", {31'd0, fault}, 32'd0);
        address = 32'h0;
        @(negedge clk);
        reset = 1'b0;

        // Read-during-write on the same word.
        @(negedge clk);
        drive_fetch("rdw_old", 32'h0000_0010);
        sample_fetch();
        load_en   = 1'b1;
        load_addr = 32'h0000_0010;
        load_data = 32'hDEAD_BEEF;
        @(posedge clk);
        model[4] = 32'hDEAD_BEEF;
        sb.push_back('{"rdw_new", model_fetch(address)});
        sample_fetch();
        load_en = 1'b0;

        // Load address low bits are ignored.
        do_load(32'h0000_0017, 32'hA5A5_5A5A);
        @(negedge clk);
        drive_fetch("load_lsb_ignored", 32'h0000_0014);
        sample_fetch();
        chk("fault_clean_path", {31'd0, fault}, 32'd0);

        // Out-of-range load: dropped, sets fault.
        address = 32'h0;
        do_load(32'(4 * DEPTH), 32'hBAD0_BAD0);
        chk("oob_load_fault", {31'd0, fault}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive_fetch($sformatf("oob_mem_%0d", i), 32'(i * 4));
            sample_fetch();
        end
        address = 32'h0;
        reset_pulse("oob_fault_clr");

        // Same writes under reset: blocked, fault stays clear.
        @(negedge clk);
        reset = 1'b1;
        do_load(32'(4 * DEPTH), 32'hBAD0_BAD0);
        chk("rst_oob_fault", {31'd0, fault}, 32'd0);
        do_load(32'h0000_0008, 32'h5555_5555);
        chk("rst_load_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_fetch("rst_load_blocked", 32'h0000_0008);
        sample_fetch();
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive_fetch($sformatf("rst_mem_%0d", i), 32'(i * 4));
            sample_fetch();
        end
        address = 32'h0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
